// File: rtl/signal_pkg.sv
// Shared definitions for the debounce stage: FSM encoding and board-clock defaults.
package signal_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b11,
    WAIT_LO   = 2'b10
  } state_t;

  // 1 ms of stability at the 50 MHz board clock.
  localparam int unsigned DEFAULT_STABLE_CNT = 50000;
  localparam int unsigned DEFAULT_CNT_WIDTH  = 16;

endpackage

// File: rtl/signal_debounce.sv
// Debounces a synchronised single-bit level and emits one-cycle rise/fall strobes
// once the new level has been held for STABLE_CNT consecutive samples.
module signal_debounce
  import signal_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = DEFAULT_CNT_WIDTH,
  parameter int unsigned STABLE_CNT  = DEFAULT_STABLE_CNT,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic sig_out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned     CW1         = CNT_WIDTH + 1;
  localparam logic [CW1-1:0]  TARGET      = CW1'(STABLE_CNT);
  localparam state_t          RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;
  localparam logic            INSTANT     = (STABLE_CNT == 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CW1-1:0]       cnt_inc;

  // One extra bit so STABLE_CNT == 2^CNT_WIDTH is still reachable by the compare.
  assign cnt_inc = {1'b0, cnt} + CW1'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RESET_STATE;
      cnt     <= '0;
      sig_out <= RESET_LEVEL;
      rise    <= 1'b0;
      fall    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (sig_in) begin
            if (INSTANT) begin
              state   <= STABLE_HI;
              sig_out <= 1'b1;
              rise    <= 1'b1;
            end else begin
              state <= WAIT_HI;
              cnt   <= CNT_WIDTH'(1);
              busy  <= 1'b1;
            end
          end
        end
        WAIT_HI: begin
          if (!sig_in) begin
            state <= STABLE_LO;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt_inc == TARGET) begin
            state   <= STABLE_HI;
            cnt     <= '0;
            busy    <= 1'b0;
            sig_out <= 1'b1;
            rise    <= 1'b1;
          end else begin
            cnt <= cnt_inc[CNT_WIDTH-1:0];
          end
        end
        STABLE_HI: begin
          if (!sig_in) begin
            if (INSTANT) begin
              state   <= STABLE_LO;
              sig_out <= 1'b0;
              fall    <= 1'b1;
            end else begin
              state <= WAIT_LO;
              cnt   <= CNT_WIDTH'(1);
              busy  <= 1'b1;
            end
          end
        end
        WAIT_LO: begin
          if (sig_in) begin
            state <= STABLE_HI;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt_inc == TARGET) begin
            state   <= STABLE_LO;
            cnt     <= '0;
            busy    <= 1'b0;
            sig_out <= 1'b0;
            fall    <= 1'b1;
          end else begin
            cnt <= cnt_inc[CNT_WIDTH-1:0];
          end
        end
        default: begin
          state   <= RESET_STATE;
          cnt     <= '0;
          sig_out <= RESET_LEVEL;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signal_debounce.sv
// Directed bench for signal_debounce: STABLE_CNT=4 main instance plus a
// RESET_LEVEL=1 / STABLE_CNT=1 variant. Expected {sig_out,rise,fall,busy} go through a queue.
module tb_signal_debounce;

  logic clk = 1'b0;
  logic rst_n, rst2_n;
  logic sig_in, sig_in2;
  logic sig_out, rise, fall, busy;
  logic sig_out2, rise2, fall2, busy2;

  int tests = 0;
  int failed = 0;
  int rise_seen = 0;
  int fall_seen = 0;

  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  signal_debounce #(.CNT_WIDTH(3), .STABLE_CNT(4), .RESET_LEVEL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
    .sig_out(sig_out), .rise(rise), .fall(fall), .busy(busy)
  );

  signal_debounce #(.CNT_WIDTH(1), .STABLE_CNT(1), .RESET_LEVEL(1'b1)) dut2 (
    .clk(clk), .rst_n(rst2_n), .sig_in(sig_in2),
    .sig_out(sig_out2), .rise(rise2), .fall(fall2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed {out,rise,fall,busy}=%b expected %b", tag, obs, expv);
    end
  endtask

  // Drive one sample of the main instance, clock it, then compare against the queued expectation.
  task automatic step(input logic s, input logic [3:0] expv, input string tag);
    logic [3:0] obs;
    sig_in = s;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    obs = {sig_out, rise, fall, busy};
    rise_seen += int'(rise);
    fall_seen += int'(fall);
    chk(tag, obs, exp_q.pop_front());
  endtask

  task automatic step2(input logic s, input logic [3:0] expv, input string tag);
    logic [3:0] obs;
    sig_in2 = s;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    obs = {sig_out2, rise2, fall2, busy2};
    chk(tag, obs, exp_q.pop_front());
  endtask

  initial begin
    rst_n   = 1'b0;
    rst2_n  = 1'b0;
    sig_in  = 1'b0;
    sig_in2 = 1'b1;

    // Reset held with the input toggling: outputs stay at reset values.
    for (int i = 0; i < 6; i++) step(1'(i % 2), 4'b0000, "reset_hold");
    chk("reset2_level", {sig_out2, rise2, fall2, busy2}, 4'b1000);
    rst_n  = 1'b1;
    rst2_n = 1'b1;

    for (int i = 0; i < 20; i++) step(1'b0, 4'b0000, "idle_after_reset");

    // Clean press: busy for three edges, accept on the fourth sample.
    step(1'b1, 4'b0001, "press_s1");
    step(1'b1, 4'b0001, "press_s2");
    step(1'b1, 4'b0001, "press_s3");
    step(1'b1, 4'b1100, "press_accept");
    step(1'b1, 4'b1000, "press_hold1");
    step(1'b1, 4'b1000, "press_hold2");

    // From high: glitch on the last sample cancels the release.
    step(1'b0, 4'b1001, "rel_glitch_s1");
    step(1'b0, 4'b1001, "rel_glitch_s2");
    step(1'b0, 4'b1001, "rel_glitch_s3");
    step(1'b1, 4'b1000, "rel_glitch_cancel");
    step(1'b1, 4'b1000, "rel_glitch_stay");
    fall_seen = 0;
    step(1'b0, 4'b1001, "rel_s1");
    step(1'b0, 4'b1001, "rel_s2");
    step(1'b0, 4'b1001, "rel_s3");
    step(1'b0, 4'b0010, "rel_accept");
    step(1'b0, 4'b0000, "rel_hold1");
    step(1'b0, 4'b0000, "rel_hold2");
    tests++;
    assert (fall_seen == 1) else begin
      failed++;
      $error("FAIL release_fall_count: observed %0d expected 1", fall_seen);
    end

    // Bounce 1,1,1,0,1,1,1,1: the dip restarts timing, exactly one rise.
    rise_seen = 0;
    step(1'b1, 4'b0001, "bounce_s1");
    step(1'b1, 4'b0001, "bounce_s2");
    step(1'b1, 4'b0001, "bounce_s3");
    step(1'b0, 4'b0000, "bounce_dip");
    step(1'b1, 4'b0001, "bounce_r1");
    step(1'b1, 4'b0001, "bounce_r2");
    step(1'b1, 4'b0001, "bounce_r3");
    step(1'b1, 4'b1100, "bounce_accept");
    step(1'b1, 4'b1000, "bounce_hold1");
    step(1'b1, 4'b1000, "bounce_hold2");
    tests++;
    assert (rise_seen == 1) else begin
      failed++;
      $error("FAIL bounce_rise_count: observed %0d expected 1", rise_seen);
    end

    // Return low before the reset-mid-wait scenario.
    step(1'b0, 4'b1001, "down_s1");
    step(1'b0, 4'b1001, "down_s2");
    step(1'b0, 4'b1001, "down_s3");
    step(1'b0, 4'b0010, "down_accept");
    step(1'b0, 4'b0000, "down_hold");

    // Reset at the second sample of a 0->1 change discards the candidate.
    rise_seen = 0;
    step(1'b1, 4'b0001, "midwait_s1");
    rst_n = 1'b0;
    #1;
    chk("midwait_async", {sig_out, rise, fall, busy}, 4'b0000);
    step(1'b1, 4'b0000, "midwait_in_reset");
    rst_n = 1'b1;
    step(1'b1, 4'b0001, "after_rst_s1");
    step(1'b1, 4'b0001, "after_rst_s2");
    step(1'b1, 4'b0001, "after_rst_s3");
    step(1'b1, 4'b1100, "after_rst_accept");
    step(1'b1, 4'b1000, "after_rst_hold");
    tests++;
    assert (rise_seen == 1) else begin
      failed++;
      $error("FAIL midwait_rise_count: observed %0d expected 1", rise_seen);
    end

    // STABLE_CNT=1, RESET_LEVEL=1 variant: one-register delay, busy never set.
    step2(1'b1, 4'b1000, "v_idle_high");
    step2(1'b0, 4'b0010, "v_fall");
    step2(1'b0, 4'b0000, "v_low_hold");
    step2(1'b1, 4'b1100, "v_rise");
    step2(1'b0, 4'b0010, "v_fall_again");
    step2(1'b1, 4'b1100, "v_rise_again");
    step2(1'b1, 4'b1000, "v_high_hold");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
